// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset/lock sequencer.
package pll_reset_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain, clearing on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// Sequences the PLL reset, qualifies lock over a stability window and
// releases the downstream system reset; retries on timeout and re-resets
// the system when lock is lost.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ABC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int MAX_CNT = (MAX_ABC > SYNC_STAGES) ? MAX_ABC : SYNC_STAGES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  // STABLE entry itself consumes one cycle of the window, hence the -2.
  localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE - 2);

  logic               locked_s;
  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [RETRY_W-1:0] retry_next;
  logic               lock_lost_next;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= PLL_RST_LOAD;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pll_rst     <= (state_next == PLL_RST);
      sys_rst     <= (state_next != RUN);
      ready       <= (state_next == RUN);
      lock_lost   <= lock_lost_next;
      retry_count <= retry_next;
    end
  end

  // Next-state logic; lock beats timeout, a drop beats window completion.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt - CNT_W'(1);
    retry_next     = retry_count;
    lock_lost_next = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == '0) begin
          state_next = WAIT_LOCK;
          cnt_next   = TIMEOUT_LOAD;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = STABLE_LOAD;
        end else if (cnt == '0) begin
          state_next = PLL_RST;
          cnt_next   = PLL_RST_LOAD;
          retry_next = sat_inc(retry_count);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = TIMEOUT_LOAD;
        end else if (cnt == '0) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        cnt_next = cnt;
        if (!locked_s) begin
          state_next     = PLL_RST;
          cnt_next       = PLL_RST_LOAD;
          lock_lost_next = 1'b1;
        end
      end
      default: begin
        state_next = PLL_RST;
        cnt_next   = PLL_RST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: a phase/age model of the
// sequencer compared every cycle, plus hand-computed checkpoints.
module tb_pll_reset_ctrl;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int LOCK_STABLE    = 8;
  localparam int SYNC_STAGES    = 2;

  localparam int PH_PLL  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_QUAL = 2;
  localparam int PH_RUN  = 3;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: phase, cycles spent in it, highs seen while qualifying.
  int m_phase;
  int m_age;
  int m_highs;
  int m_retries;
  bit m_lost;
  bit m_ls;
  bit m_sync [SYNC_STAGES];

  pll_reset_ctrl #(
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .LOCK_STABLE    (LOCK_STABLE),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic locked_v);
    #2;
    rst    = rst_v;
    locked = locked_v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Behavioural model advanced on every rising edge, reset asynchronously.
  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase   = PH_PLL;
      m_age     = 0;
      m_highs   = 0;
      m_retries = 0;
      m_lost    = 0;
      for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;
    end else begin
      m_ls = m_sync[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = locked;
      m_lost = 0;
      m_age++;
      case (m_phase)
        PH_PLL: begin
          if (m_age == PLL_RST_CYCLES) begin
            m_phase = PH_WAIT;
            m_age   = 0;
          end
        end
        PH_WAIT: begin
          if (m_ls) begin
            m_phase = PH_QUAL;
            m_age   = 0;
            m_highs = 1;
          end else if (m_age == LOCK_TIMEOUT) begin
            if (m_retries < 255) m_retries++;
            m_phase = PH_PLL;
            m_age   = 0;
          end
        end
        PH_QUAL: begin
          if (!m_ls) begin
            m_phase = PH_WAIT;
            m_age   = 0;
          end else begin
            m_highs++;
            if (m_highs == LOCK_STABLE) begin
              m_phase = PH_RUN;
              m_age   = 0;
            end
          end
        end
        default: begin
          if (!m_ls) begin
            m_lost  = 1;
            m_phase = PH_PLL;
            m_age   = 0;
          end
        end
      endcase
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge refclk) begin
    if (check_en) begin
      checkOutput("model pll_rst", 8'(pll_rst), 8'(m_phase == PH_PLL));
      checkOutput("model sys_rst", 8'(sys_rst), 8'(m_phase != PH_RUN));
      checkOutput("model ready", 8'(ready), 8'(m_phase == PH_RUN));
      checkOutput("model lock_lost", 8'(lock_lost), 8'(m_lost));
      checkOutput("model retry_count", retry_count, 8'(m_retries));
    end
  end

  // Directed scenarios with hand-computed checkpoints.
  initial begin
    rst    = 1'b0;
    locked = 1'b0;
    #1 rst = 1'b1;
    tick(2);
    check_en = 1'b1;
    checkOutput("reset pll_rst", 8'(pll_rst), 8'd1);
    checkOutput("reset sys_rst", 8'(sys_rst), 8'd1);
    checkOutput("reset ready", 8'(ready), 8'd0);
    checkOutput("reset lock_lost", 8'(lock_lost), 8'd0);
    checkOutput("reset retry", retry_count, 8'd0);

    // Clean lock
    applyStimulus(1'b0, 1'b0);
    tick(3);
    checkOutput("clean pll_rst edge3", 8'(pll_rst), 8'd1);
    tick(1);
    checkOutput("clean pll_rst edge4", 8'(pll_rst), 8'd0);
    checkOutput("clean sys_rst edge4", 8'(sys_rst), 8'd1);
    tick(6);
    applyStimulus(1'b0, 1'b1);
    tick(9);
    checkOutput("clean sys_rst held", 8'(sys_rst), 8'd1);
    checkOutput("clean ready held", 8'(ready), 8'd0);
    tick(1);
    checkOutput("clean sys_rst release", 8'(sys_rst), 8'd0);
    checkOutput("clean ready", 8'(ready), 8'd1);
    checkOutput("clean retry", retry_count, 8'd0);

    // Loss of lock in RUN
    tick(2);
    applyStimulus(1'b0, 1'b0);
    tick(2);
    checkOutput("loss lock_lost early", 8'(lock_lost), 8'd0);
    checkOutput("loss ready early", 8'(ready), 8'd1);
    tick(1);
    checkOutput("loss lock_lost pulse", 8'(lock_lost), 8'd1);
    checkOutput("loss sys_rst", 8'(sys_rst), 8'd1);
    checkOutput("loss ready", 8'(ready), 8'd0);
    checkOutput("loss pll_rst", 8'(pll_rst), 8'd1);
    tick(1);
    checkOutput("loss lock_lost end", 8'(lock_lost), 8'd0);
    tick(2);
    checkOutput("loss pll_rst 4th", 8'(pll_rst), 8'd1);
    tick(1);
    checkOutput("loss pll_rst drop", 8'(pll_rst), 8'd0);

    // Glitchy lock: 5 high, 1 low, then high
    applyStimulus(1'b0, 1'b1);
    tick(5);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("glitch sys_rst", 8'(sys_rst), 8'd1);
    tick(9);
    checkOutput("glitch sys_rst held", 8'(sys_rst), 8'd1);
    tick(1);
    checkOutput("glitch sys_rst release", 8'(sys_rst), 8'd0);
    checkOutput("glitch ready", 8'(ready), 8'd1);
    checkOutput("glitch retry", retry_count, 8'd0);

    // Timeout with locked held low
    applyStimulus(1'b1, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0);
    tick(35);
    checkOutput("timeout retry before", retry_count, 8'd0);
    checkOutput("timeout pll_rst before", 8'(pll_rst), 8'd0);
    tick(1);
    checkOutput("timeout retry 1", retry_count, 8'd1);
    checkOutput("timeout pll_rst repulse", 8'(pll_rst), 8'd1);
    tick(3);
    checkOutput("timeout pll_rst 4th", 8'(pll_rst), 8'd1);
    tick(1);
    checkOutput("timeout pll_rst drop", 8'(pll_rst), 8'd0);
    tick(31);
    checkOutput("timeout retry still 1", retry_count, 8'd1);
    tick(1);
    checkOutput("timeout retry 2", retry_count, 8'd2);
    tick(28);
    checkOutput("timeout sys_rst", 8'(sys_rst), 8'd1);
    checkOutput("timeout retry end", retry_count, 8'd2);

    // Async reset in the middle of the stability window
    applyStimulus(1'b0, 1'b1);
    tick(5);
    checkOutput("midstable sys_rst", 8'(sys_rst), 8'd1);
    checkOutput("midstable pll_rst", 8'(pll_rst), 8'd0);
    checkOutput("midstable retry", retry_count, 8'd2);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("async pll_rst", 8'(pll_rst), 8'd1);
    checkOutput("async sys_rst", 8'(sys_rst), 8'd1);
    checkOutput("async ready", 8'(ready), 8'd0);
    checkOutput("async lock_lost", 8'(lock_lost), 8'd0);
    checkOutput("async retry", retry_count, 8'd0);

    // Saturation of the retry counter
    tick(2);
    applyStimulus(1'b0, 1'b0);
    tick(36 * 255 - 1);
    checkOutput("sat retry 254", retry_count, 8'd254);
    tick(1);
    checkOutput("sat retry 255", retry_count, 8'd255);
    tick(220);
    checkOutput("sat retry held", retry_count, 8'd255);
    checkOutput("sat sys_rst", 8'(sys_rst), 8'd1);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
